// File: rtl/lz77_pkg.sv
// Shared LZ77 window geometry, codeword layout and decoder state encoding,
// common to the encoder and decoder.
package lz77_pkg;

  localparam int W_CHAR     = 8;
  localparam int SEARCH_LEN = 9;
  localparam int LOOK_LEN   = 8;
  localparam int W_OFF      = 4;
  localparam int W_LEN      = 3;

  localparam logic [W_CHAR-1:0] END_SGN = 8'h24;
  localparam logic [W_OFF-1:0]  MAX_OFF = W_OFF'(SEARCH_LEN - 1);

  typedef struct packed {
    logic [W_OFF-1:0]  offset;
    logic [W_LEN-1:0]  match_len;
    logic [W_CHAR-1:0] char_nxt;
  } codeword_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COPY,
    ST_LIT,
    ST_DONE
  } dec_state_e;

endpackage

// File: rtl/lz77_search_buf.sv
// Sliding search window: newest char enters at the top index, oldest falls
// off index 0. Reset fills every entry with the end sign.
module lz77_search_buf
  import lz77_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              shift_i,
  input  logic [W_CHAR-1:0] din_i,
  input  logic [W_OFF-1:0]  rd_idx_i,
  output logic [W_CHAR-1:0] rd_data_o
);

  logic [W_CHAR-1:0] mem_q [SEARCH_LEN];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SEARCH_LEN; i++) mem_q[i] <= END_SGN;
    end else if (shift_i) begin
      for (int i = 0; i < SEARCH_LEN - 1; i++) mem_q[i] <= mem_q[i+1];
      mem_q[SEARCH_LEN-1] <= din_i;
    end
  end

  assign rd_data_o = (rd_idx_i <= MAX_OFF) ? mem_q[rd_idx_i] : END_SGN;

endmodule

// File: rtl/lz77_decoder.sv
// LZ77 decoder: expands (offset, match_len, char) codewords into a char stream
// with a registered valid/ready output; stops after decoding the end sign.
module lz77_decoder
  import lz77_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W_OFF-1:0]  in_offset,
  input  logic [W_LEN-1:0]  in_match_len,
  input  logic [W_CHAR-1:0] in_char,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W_CHAR-1:0] out_char,
  output logic              finish,
  output logic              err
);

  function automatic logic [W_OFF-1:0] clamp_off(input logic [W_OFF-1:0] off);
    return (off > MAX_OFF) ? MAX_OFF : off;
  endfunction

  dec_state_e        state_q, state_d;
  logic [W_OFF-1:0]  idx_q, idx_d;
  logic [W_LEN-1:0]  len_q, len_d;
  logic [W_CHAR-1:0] char_q, char_d;
  logic [W_CHAR-1:0] out_char_q, out_char_d;
  logic              finish_q, finish_d;
  logic              err_q, err_d;
  logic              shift;
  logic [W_OFF-1:0]  rd_idx;
  logic [W_CHAR-1:0] rd_data;
  codeword_t         cw_in;

  assign cw_in = '{offset: in_offset, match_len: in_match_len, char_nxt: in_char};

  lz77_search_buf u_buf (
    .clk       (clk),
    .reset     (reset),
    .shift_i   (shift),
    .din_i     (out_char_q),
    .rd_idx_i  (rd_idx),
    .rd_data_o (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      out_char_q <= '0;
      finish_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_char_q <= out_char_d;
      finish_q   <= finish_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    idx_q  <= idx_d;
    len_q  <= len_d;
    char_q <= char_d;
  end

  // out_char is preloaded one char ahead: during a copy the next char sits at
  // idx+1 of the pre-shift window, or is the char being emitted when idx is newest.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    char_d     = char_q;
    out_char_d = out_char_q;
    finish_d   = finish_q;
    err_d      = err_q;
    shift      = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    rd_idx     = (idx_q == MAX_OFF) ? MAX_OFF : idx_q + W_OFF'(1);

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        rd_idx   = MAX_OFF - clamp_off(cw_in.offset);
        if (in_valid) begin
          err_d  = err_q | (cw_in.offset > MAX_OFF);
          idx_d  = rd_idx;
          len_d  = cw_in.match_len;
          char_d = cw_in.char_nxt;
          if (cw_in.match_len != '0) begin
            state_d    = ST_COPY;
            out_char_d = rd_data;
          end else begin
            state_d    = ST_LIT;
            out_char_d = cw_in.char_nxt;
          end
        end
      end
      ST_COPY: begin
        out_valid = 1'b1;
        if (out_ready) begin
          shift = 1'b1;
          len_d = len_q - W_LEN'(1);
          if (len_q == W_LEN'(1)) begin
            state_d    = ST_LIT;
            out_char_d = char_q;
          end else begin
            out_char_d = (idx_q == MAX_OFF) ? out_char_q : rd_data;
          end
        end
      end
      ST_LIT: begin
        if (char_q == END_SGN) begin
          finish_d = 1'b1;
          state_d  = ST_DONE;
        end else begin
          out_valid = 1'b1;
          if (out_ready) begin
            shift   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_DONE: begin
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign out_char = out_char_q;
  assign finish   = finish_q;
  assign err      = err_q;

endmodule

// File: tb/tb_lz77_decoder.sv
// Bench for lz77_decoder: directed scenarios plus random codewords, checked
// against a history-queue model of LZ77 decoding.
module tb_lz77_decoder;

  logic       clk = 1'b0;
  logic       reset, in_valid, in_ready, out_valid, out_ready, finish, err;
  logic [3:0] in_offset;
  logic [2:0] in_match_len;
  logic [7:0] in_char, out_char;

  always #5 clk = ~clk;

  lz77_decoder dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_offset    (in_offset),
    .in_match_len (in_match_len),
    .in_char      (in_char),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_char     (out_char),
    .finish       (finish),
    .err          (err)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] hist[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] want[$];
  bit         exp_err;
  int         rdy_mode;
  logic [3:0] rdy_pat;
  int         cyc_used, stall_glitch;
  bit         timed_out;
  logic       first_valid;

  // Decoding model: copy from the full history, counting back from the newest char.
  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 9; i++) hist.push_back(8'h24);
    exp_err = 0;
  endtask

  task automatic model_cw(input int off, input int len, input logic [7:0] ch);
    int o;
    logic [7:0] c;
    o = (off > 8) ? 8 : off;
    if (off > 8) exp_err = 1;
    exp_q.delete();
    for (int k = 0; k < len; k++) begin
      c = hist[hist.size() - 1 - o];
      exp_q.push_back(c);
      hist.push_back(c);
    end
    if (ch != 8'h24) begin
      exp_q.push_back(ch);
      hist.push_back(ch);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  // Offers one codeword, then collects emitted chars until the decoder is idle or finished.
  task automatic drive_cw(input int off, input int len, input logic [7:0] ch);
    logic [7:0] prev_c;
    bit prev_stall;
    int guard, rix;
    got_q.delete();
    timed_out = 0; stall_glitch = 0; cyc_used = 0; prev_stall = 0; prev_c = '0; rix = 0;
    model_cw(off, len, ch);
    in_offset = off[3:0]; in_match_len = len[2:0]; in_char = ch;
    in_valid = 1'b1; out_ready = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    if (!in_ready) timed_out = 1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    first_valid = out_valid;
    for (int c = 0; c < 200; c++) begin
      if (in_ready || finish) break;
      if (prev_stall && (!out_valid || out_char !== prev_c)) stall_glitch++;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = rdy_pat[rix % 4];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      rix++;
      if (out_valid && out_ready) got_q.push_back(out_char);
      prev_stall = out_valid && !out_ready;
      prev_c = out_char;
      @(posedge clk); #1;
      cyc_used++;
    end
    if (!(in_ready || finish)) timed_out = 1;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_offset = '0; in_match_len = '0; in_char = '0;
    @(posedge clk); #1;
    apply_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_char !== 8'h00) begin errors++; $display("FAIL reset_out_char got=%h want=00", out_char); end
    checks++; if (finish !== 1'b0) begin errors++; $display("FAIL reset_finish got=%b want=0", finish); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", err); end
  endtask

  task automatic test_initial_window();
    rdy_mode = 0;
    drive_cw(8, 2, 8'h78);
    want = '{8'h24, 8'h24, 8'h78};
    checks++; if (got_q.size() != want.size() || timed_out) begin errors++; $display("FAIL init_count got=%0d want=%0d timeout=%0d", got_q.size(), want.size(), timed_out); end
    foreach (want[i]) begin
      checks++; if (i >= got_q.size() || got_q[i] !== want[i]) begin errors++; $display("FAIL init_char[%0d] got=%h want=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, want[i]); end
    end
    checks++; if (finish !== 1'b0) begin errors++; $display("FAIL init_finish got=%b want=0", finish); end
  endtask

  task automatic test_overlap();
    rdy_mode = 0;
    drive_cw(0, 0, 8'h41);
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'h41) begin errors++; $display("FAIL ovl_lit got_n=%0d want A", got_q.size()); end
    drive_cw(0, 3, 8'h42);
    checks++; if (first_valid !== 1'b1) begin errors++; $display("FAIL ovl_latency out_valid=%b want=1 one cycle after accept", first_valid); end
    want = '{8'h41, 8'h41, 8'h41, 8'h42};
    checks++; if (got_q.size() != want.size()) begin errors++; $display("FAIL ovl_count got=%0d want=%0d", got_q.size(), want.size()); end
    foreach (want[i]) begin
      checks++; if (i >= got_q.size() || got_q[i] !== want[i]) begin errors++; $display("FAIL ovl_char[%0d] got=%h want=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, want[i]); end
    end
  endtask

  task automatic test_backref();
    rdy_mode = 0;
    for (int i = 0; i < 4; i++) drive_cw(0, 0, 8'h41 + 8'(i));
    drive_cw(3, 4, 8'h45);
    want = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    checks++; if (cyc_used != 5) begin errors++; $display("FAIL bref_cycles got=%0d want=5", cyc_used); end
    checks++; if (got_q.size() != want.size()) begin errors++; $display("FAIL bref_count got=%0d want=%0d", got_q.size(), want.size()); end
    foreach (want[i]) begin
      checks++; if (i >= got_q.size() || got_q[i] !== want[i]) begin errors++; $display("FAIL bref_char[%0d] got=%h want=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, want[i]); end
    end
    drive_cw(4, 5, 8'h46);
    want = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    foreach (want[i]) begin
      checks++; if (i >= got_q.size() || got_q[i] !== want[i]) begin errors++; $display("FAIL bref_window[%0d] got=%h want=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, want[i]); end
    end
  endtask

  task automatic test_backpressure();
    rdy_mode = 1; rdy_pat = 4'b1001;
    drive_cw(2, 3, 8'h47);
    want = '{8'h44, 8'h45, 8'h46, 8'h47};
    checks++; if (stall_glitch != 0) begin errors++; $display("FAIL bp_stable glitches=%0d want=0", stall_glitch); end
    checks++; if (got_q.size() != want.size() || timed_out) begin errors++; $display("FAIL bp_count got=%0d want=%0d timeout=%0d", got_q.size(), want.size(), timed_out); end
    foreach (want[i]) begin
      checks++; if (i >= got_q.size() || got_q[i] !== want[i]) begin errors++; $display("FAIL bp_char[%0d] got=%h want=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, want[i]); end
    end
    rdy_mode = 0;
  endtask

  task automatic test_random();
    int off, len;
    logic [7:0] ch;
    rdy_mode = 2;
    for (int n = 0; n < 40; n++) begin
      off = int'($urandom_range(0, 8));
      len = int'($urandom_range(0, 7));
      ch = 8'($urandom_range(32, 126));
      if (ch == 8'h24) ch = 8'h61;
      drive_cw(off, len, ch);
      checks++; if (got_q.size() != exp_q.size() || timed_out) begin errors++; $display("FAIL rnd%0d_count got=%0d want=%0d timeout=%0d", n, got_q.size(), exp_q.size(), timed_out); end
      foreach (exp_q[i]) begin
        checks++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_char[%0d] got=%h want=%h", n, i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]); end
      end
    end
    checks++; if (err !== exp_err) begin errors++; $display("FAIL rnd_err got=%b want=%b", err, exp_err); end
    rdy_mode = 0;
  endtask

  task automatic test_illegal();
    apply_reset();
    rdy_mode = 0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ill_err_pre got=%b want=0", err); end
    drive_cw(12, 1, 8'h51);
    want = '{8'h24, 8'h51};
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ill_err got=%b want=1", err); end
    checks++; if (got_q.size() != want.size()) begin errors++; $display("FAIL ill_count got=%0d want=%0d", got_q.size(), want.size()); end
    foreach (want[i]) begin
      checks++; if (i >= got_q.size() || got_q[i] !== want[i]) begin errors++; $display("FAIL ill_char[%0d] got=%h want=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, want[i]); end
    end
    drive_cw(0, 0, 8'h52);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ill_sticky got=%b want=1", err); end
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'h52) begin errors++; $display("FAIL ill_after got_n=%0d want R", got_q.size()); end
  endtask

  task automatic test_end();
    rdy_mode = 0;
    drive_cw(0, 0, 8'h24);
    checks++; if (first_valid !== 1'b0) begin errors++; $display("FAIL end_no_valid got=%b want=0", first_valid); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL end_emitted got=%0d want=0", got_q.size()); end
    checks++; if (cyc_used != 1 || finish !== 1'b1) begin errors++; $display("FAIL end_finish finish=%b after %0d cycles want 1 after 1", finish, cyc_used); end
    in_valid = 1'b1; in_offset = 4'd0; in_match_len = 3'd2; in_char = 8'h53;
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL end_in_ready got=%b want=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL end_out_valid got=%b want=0", out_valid); end
    checks++; if (finish !== 1'b1) begin errors++; $display("FAIL end_hold got=%b want=1", finish); end
  endtask

  task automatic test_reset_done();
    apply_reset();
    checks++; if (finish !== 1'b0) begin errors++; $display("FAIL rstd_finish got=%b want=0", finish); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstd_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstd_out_valid got=%b want=0", out_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rstd_err got=%b want=0", err); end
  endtask

  task automatic test_reset_copy();
    in_offset = 4'd0; in_match_len = 3'd7; in_char = 8'h5a; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstc_copying out_valid=%b want=1", out_valid); end
    repeat (2) begin @(posedge clk); #1; end
    apply_reset();
    checks++; if (finish !== 1'b0) begin errors++; $display("FAIL rstc_finish got=%b want=0", finish); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstc_out_valid got=%b want=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstc_in_ready got=%b want=1", in_ready); end
    checks++; if (out_char !== 8'h00) begin errors++; $display("FAIL rstc_out_char got=%h want=00", out_char); end
    rdy_mode = 0;
    drive_cw(8, 7, 8'h71);
    want = '{8'h24, 8'h24, 8'h24, 8'h24, 8'h24, 8'h24, 8'h24, 8'h71};
    checks++; if (got_q.size() != want.size()) begin errors++; $display("FAIL rstc_count got=%0d want=%0d", got_q.size(), want.size()); end
    foreach (want[i]) begin
      checks++; if (i >= got_q.size() || got_q[i] !== want[i]) begin errors++; $display("FAIL rstc_buf[%0d] got=%h want=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, want[i]); end
    end
  endtask

  initial begin
    rdy_mode = 0; rdy_pat = 4'b1111;
    test_reset();
    test_initial_window();
    test_overlap();
    test_backref();
    test_backpressure();
    test_random();
    test_illegal();
    test_end();
    test_reset_done();
    test_end();
    test_reset_done();
    test_reset_copy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lz77_decoder.md
Name: lz77_decoder

Overview:
- Downstream consumer of the LZ77 encoder's codeword stream (offset, match_len, char_nxt).
- Rebuilds the original character stream from a 9-char sliding search buffer and emits one char per handshake.
- On receiving the '$' end sign as literal, asserts finish and stops accepting input.
- Uses the same window geometry as the encoder: 9-char search buffer, 4-bit offset, 3-bit match length.

Parameters:
W_CHAR, 8, char width in bits
SEARCH_LEN, 9, search buffer depth in chars
W_OFF, 4, offset field width
W_LEN, 3, match length field width
END_SGN, 8'h24, end-of-stream char ('$'); also the initial fill of the search buffer

Ports:
clk  in  1  clock
reset  in  1  sync active-high reset
in_valid  in  1  codeword present
in_ready  out  1  decoder can accept a codeword
in_offset  in  W_OFF  distance back from newest char (0 = newest)
in_match_len  in  W_LEN  chars to copy (0..7)
in_char  in  W_CHAR  literal following the copy
out_valid  out  1  out_char valid
out_ready  in  1  consumer accepts out_char
out_char  out  W_CHAR  decoded char
finish  out  1  end sign decoded; held high until reset
err  out  1  sticky: codeword with offset > SEARCH_LEN-1 received

Behaviour:
- Interface: clock clk; reset reset, synchronous, active-high.
- Reset (sync, any state, including mid-copy):
  - state = IDLE; all search buffer entries = END_SGN.
  - out_valid = 0, out_char = 0, finish = 0, err = 0, in_ready = 1 on the cycle after reset deasserts.
- Search buffer buf[0..8]: buf[8] is the newest char. Every out handshake (out_valid && out_ready) shifts buf left by one and writes the emitted char into buf[8].
- Copy source index = SEARCH_LEN-1-offset. The index stays constant during a copy because the buffer shifts each emit, so overlapping matches (match_len > offset+1) self-replicate correctly.
- States:
  - IDLE: in_ready = 1, out_valid = 0. On in_valid, latch off/len/char.
    - If in_offset > 8: err <= 1 and latched offset clamped to 8.
    - Next state = COPY if len != 0, else LIT.
  - COPY: in_ready = 0, out_valid = 1, out_char = buf[8-off].
    - On out_ready: shift, and len <= len-1.
    - When len == 1 at the handshake, next state = LIT.
    - Without out_ready, all state holds and out_char is stable.
  - LIT, char != END_SGN: out_valid = 1, out_char = latched char. On out_ready: shift, go to IDLE.
  - LIT, char == END_SGN: out_valid = 0, no shift. finish <= 1, go to DONE. The '$' is never emitted.
  - DONE: in_ready = 0, out_valid = 0, finish = 1. Stays until reset.
- Timing:
  - Codeword accepted in cycle N → first out_valid in cycle N+1.
  - With out_ready tied high, one codeword costs match_len+2 cycles (1 accept + match_len copies + 1 literal).
  - finish rises the cycle after LIT is entered with the end sign.
- out_char is registered; no combinational path from in_* to out_*.
- in_* are ignored whenever in_ready = 0.
- finish and err are registered.

Decomposition:
- Shared package lz77_pkg holds W_CHAR, SEARCH_LEN, LOOK_LEN (8), W_OFF, W_LEN, END_SGN and the codeword struct {offset, match_len, char_nxt}. The encoder uses the same package.
- One natural sub-module: lz77_search_buf, a 9-entry shift register with reset fill of END_SGN, a shift-enable/insert port and a read port by index. The FSM stays in lz77_decoder.

Test Plan:
- Initial window: (8,2,'x') → out 24,24,78 ('$','$','x'); finish = 0.
- Literal then overlap: (0,0,'A'), then (0,3,'B') → A, A, A, A, B. Second codeword's first out_valid is 1 cycle after its accept.
- Back-reference: after "ABCD" emitted as literals, (3,4,'E') → A, B, C, D, E. The buffer's last 5 entries are "ABCDE".
- Backpressure: out_ready toggles 1,0,0,1 during a copy → out_char holds stable while stalled. No char is lost or duplicated; in_ready stays 0 until LIT completes.
- End and reset: (0,0,'$') → no out_valid, finish = 1 the next cycle, in_ready = 0 thereafter. Then reset mid-DONE, and reset mid-COPY of (0,7,'Z') → next cycle finish = 0, out_valid = 0, in_ready = 1, buffer is all '$'.
- Illegal offset: (12,1,'Q') → err = 1 (sticky), copy uses offset 8 → out '$','Q'.
